// File: rtl/spi_pkg.sv
// Shared types for the SPI monarch: FSM states and the per-transfer bus mode.
// Pure type definitions; no logic, latency or flow control here.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, FRONT, XFER, BACK} spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles SCLK every 2**(DIV_W-1) clk cycles while enabled, flags edges one cycle ahead.
// Edge pulses are combinational and coincide with the clk edge that moves SCLK; no backpressure.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic idle_lvl_i,
  input  logic cpol_i,
  input  logic en_i,
  output logic sclk_o,
  output logic tick_o,
  output logic lead_edge_o,
  output logic trail_edge_o
);

  localparam int CW = DIV_W - 1;

  logic [CW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  // Counter wraps naturally at HALF, so the all-ones value marks the last cycle of a half period.
  assign tick = &div_q;

  always_comb begin
    div_d  = div_q + CW'(1);
    sclk_d = sclk_q;
    if (load_i) begin
      div_d  = '0;
      sclk_d = idle_lvl_i;
    end else if (en_i && tick) begin
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o       = sclk_q;
  assign tick_o       = tick;
  assign lead_edge_o  = en_i && tick && (sclk_q == cpol_i);
  assign trail_edge_o = en_i && tick && (sclk_q != cpol_i);

endmodule

// File: rtl/spi_mnrch_gen.sv
// SPI monarch: one full-duplex DATA_W-bit transfer per snd pulse, (2*DATA_W+1)*HALF cycles to done.
// snd is only honoured in IDLE; pulses while busy are dropped without disturbing the transfer.
module spi_mnrch_gen
  import spi_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DIV_W    = 5,
  parameter int NUM_SERF = 1,
  parameter int SEL_W    = (NUM_SERF > 1) ? $clog2(NUM_SERF) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                snd,
  input  logic [DATA_W-1:0]   cmd,
  input  logic [SEL_W-1:0]    serf_sel,
  input  logic                cpol,
  input  logic                cpha,
  output logic [DATA_W-1:0]   resp,
  output logic                done,
  output logic                busy,
  output logic [NUM_SERF-1:0] SS_n,
  output logic                SCLK,
  output logic                MOSI,
  input  logic                MISO
);

  localparam int EDGES = 2 * DATA_W;
  localparam int CNT_W = $clog2(EDGES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(EDGES - 1);

  spi_state_t          state_q, state_d;
  logic [DATA_W-1:0]   shft_q, shft_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic                miso_q, miso_d;
  spi_mode_t           mode_q, mode_d;
  logic [CNT_W-1:0]    edge_q, edge_d;
  logic                fin_q, fin_d;
  logic                done_q, done_d;
  logic [NUM_SERF-1:0] ss_n_q, ss_n_d;
  logic [NUM_SERF-1:0] sel_dec;

  logic sclk_load, sclk_en, sclk, tick, lead_edge, trail_edge;

  assign sclk_load = (state_q == IDLE) && snd;
  assign sclk_en   = (state_q == FRONT) || (state_q == XFER);

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (sclk_load),
    .idle_lvl_i   (cpol),
    .cpol_i       (mode_q.cpol),
    .en_i         (sclk_en),
    .sclk_o       (sclk),
    .tick_o       (tick),
    .lead_edge_o  (lead_edge),
    .trail_edge_o (trail_edge)
  );

  always_comb begin
    state_d = state_q;
    shft_d  = shft_q;
    resp_d  = resp_q;
    miso_d  = miso_q;
    mode_d  = mode_q;
    edge_d  = edge_q;
    fin_d   = 1'b0;
    done_d  = done_q;
    ss_n_d  = ss_n_q;

    // Out-of-range indices match no bit, so the transfer runs with every select high.
    sel_dec = '1;
    for (int i = 0; i < NUM_SERF; i++) begin
      if (serf_sel == SEL_W'(i)) sel_dec[i] = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (snd) begin
          state_d = FRONT;
          shft_d  = cmd;
          mode_d  = '{cpol: cpol, cpha: cpha};
          edge_d  = '0;
          done_d  = 1'b0;
          ss_n_d  = sel_dec;
        end
      end
      FRONT, XFER: begin
        if (lead_edge || trail_edge) begin
          edge_d  = edge_q + CNT_W'(1);
          state_d = (edge_q == LAST) ? BACK : XFER;
        end
        if (mode_q.cpha ? trail_edge : lead_edge) miso_d = MISO;
        // CPHA=1 skips the first leading edge; the missing shift is made up just after the last edge.
        if (mode_q.cpha ? (lead_edge && edge_q != '0) : trail_edge)
          shft_d = {shft_q[DATA_W-2:0], miso_q};
        fin_d = mode_q.cpha && trail_edge && (edge_q == LAST);
      end
      BACK: begin
        if (fin_q) shft_d = {shft_q[DATA_W-2:0], miso_q};
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
          resp_d  = shft_q;
          ss_n_d  = '1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shft_q  <= '0;
      resp_q  <= '0;
      miso_q  <= 1'b0;
      mode_q  <= '{cpol: 1'b1, cpha: 1'b0};
      edge_q  <= '0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
      ss_n_q  <= '1;
    end else begin
      state_q <= state_d;
      shft_q  <= shft_d;
      resp_q  <= resp_d;
      miso_q  <= miso_d;
      mode_q  <= mode_d;
      edge_q  <= edge_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
      ss_n_q  <= ss_n_d;
    end
  end

  assign resp = resp_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);
  assign SS_n = ss_n_q;
  assign SCLK = sclk;
  assign MOSI = shft_q[DATA_W-1];

endmodule
